// File: rtl/sn_uart_rx.sv
// sn_uart_rx: oversampling UART receiver (start, LSB-first data, stop).
// Ports: clk, rst (async active-low), rx_enable, rx_input -> received_word, rx_done, rx_active.
module sn_uart_rx #(
  parameter int P_CLKS_PER_BIT        = 10,
  parameter int P_NUM_BITS_TO_RECEIVE = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_enable,
  input  logic       rx_input,
  output logic [7:0] received_word,
  output logic       rx_done,
  output logic       rx_active
);

  localparam int D  = P_NUM_BITS_TO_RECEIVE - 2;
  localparam int H  = P_CLKS_PER_BIT / 2;
  localparam int CW = $clog2(P_CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_LAST = CW'(P_CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    BIT_LAST = 3'(D - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state;
  logic [1:0]      sync;
  logic            rx_s;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;

  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx_input};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      received_word <= 8'h00;
      rx_done       <= 1'b0;
      rx_active     <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (!rx_enable) begin
        state     <= IDLE;
        rx_active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            rx_active <= 1'b0;
            if (!rx_s) begin
              state     <= START;
              clk_cnt   <= '0;
              bit_cnt   <= '0;
              shift     <= '0;
              rx_active <= 1'b1;
            end
          end
          // Mid-start-bit check rejects short glitches.
          START: begin
            if (clk_cnt == CNT_HALF) begin
              clk_cnt <= '0;
              if (rx_s) begin
                state     <= IDLE;
                rx_active <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              clk_cnt <= clk_cnt + CNT_ONE;
            end
          end
          DATA: begin
            if (clk_cnt == CNT_LAST) begin
              clk_cnt        <= '0;
              shift[bit_cnt] <= rx_s;
              if (bit_cnt == BIT_LAST) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              clk_cnt <= clk_cnt + CNT_ONE;
            end
          end
          // rx_active stays high through the rx_done cycle;
          // IDLE drops it on the following edge.
          STOP: begin
            if (clk_cnt == CNT_LAST) begin
              clk_cnt <= '0;
              if (rx_s) begin
                received_word <= shift;
                rx_done       <= 1'b1;
                state         <= IDLE;
              end else begin
                state     <= WAIT_HIGH;
                rx_active <= 1'b0;
              end
            end else begin
              clk_cnt <= clk_cnt + CNT_ONE;
            end
          end
          // A low stop bit must not be mistaken for a new start.
          WAIT_HIGH: begin
            rx_active <= 1'b0;
            if (rx_s) begin
              state <= IDLE;
            end
          end
          default: begin
            state     <= IDLE;
            rx_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sn_uart_rx.sv
// tb_sn_uart_rx: directed scoreboard bench for sn_uart_rx.
// Drives frames serially, checks words, strobes and activity timing.
module tb_sn_uart_rx;

  localparam int P = 10;
  localparam int N = 10;
  localparam int H = P / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_enable;
  logic       rx_input;
  logic [7:0] received_word;
  logic       rx_done;
  logic       rx_active;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int act_cnt  = 0;
  int cur_run  = 0;
  int max_run  = 0;
  int done_cyc[$];
  logic [7:0] exp_q[$];

  sn_uart_rx #(
    .P_CLKS_PER_BIT(P),
    .P_NUM_BITS_TO_RECEIVE(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_enable(rx_enable),
    .rx_input(rx_input),
    .received_word(received_word),
    .rx_done(rx_done),
    .rx_active(rx_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_active === 1'b1) begin
      act_cnt++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    if (rx_done === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      check("sb_pending", (exp_q.size() != 0) ? 1 : 0, 1);
      if (exp_q.size() != 0)
        check("sb_word", {24'h0, received_word}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line_bit(input logic b);
    rx_input = b;
    tick(P);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    line_bit(1'b0);
    for (int i = 0; i < N - 2; i++) line_bit(data[i]);
    line_bit(stop);
  endtask

  initial begin
    int base;
    rst       = 1'b0;
    rx_enable = 1'b0;
    rx_input  = 1'b1;
    tick(3);
    check("rst_word", {24'h0, received_word}, 32'h00);
    check("rst_done", {31'h0, rx_done}, 0);
    check("rst_active", {31'h0, rx_active}, 0);
    rst = 1'b1;
    tick(3);
    rx_enable = 1'b1;
    tick(5);
    check("idle_active", {31'h0, rx_active}, 0);

    // Frame 0x99 with activity-length measurement.
    act_cnt = 0;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    tick(5);
    check("f99_word", {24'h0, received_word}, 32'h99);
    check("f99_done_cnt", done_cnt, 1);
    check("f99_active_len", act_cnt, H + (N - 1) * P + 1);
    rx_enable = 1'b0;
    tick(150);
    check("idle_done_cnt", done_cnt, 1);
    check("idle_word", {24'h0, received_word}, 32'h99);

    // Back-to-back frames.
    rx_enable = 1'b1;
    tick(5);
    base = done_cyc.size();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hA5);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hA5, 1'b1);
    tick(10);
    check("b2b_done_cnt", done_cnt, 3);
    check("b2b_word", {24'h0, received_word}, 32'hA5);
    if (done_cyc.size() >= base + 2)
      check("b2b_spacing", done_cyc[base+1] - done_cyc[base], N * P);
    else
      check("b2b_pulses", done_cyc.size() - base, 2);

    // Start-bit glitch.
    max_run  = 0;
    rx_input = 1'b0;
    tick(3);
    rx_input = 1'b1;
    tick(30);
    check("glitch_run_ok", (max_run >= 1 && max_run <= H + 1) ? 1 : 0, 1);
    check("glitch_done_cnt", done_cnt, 3);
    check("glitch_word", {24'h0, received_word}, 32'hA5);
    check("glitch_active", {31'h0, rx_active}, 0);

    // Framing error, line then held low.
    send_frame(8'h55, 1'b0);
    tick(40);
    check("ferr_active", {31'h0, rx_active}, 0);
    check("ferr_done_cnt", done_cnt, 3);
    check("ferr_word", {24'h0, received_word}, 32'hA5);
    rx_input = 1'b1;
    tick(20);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    tick(10);
    check("f12_word", {24'h0, received_word}, 32'h12);
    check("f12_done_cnt", done_cnt, 4);

    // Abort at data bit 4.
    line_bit(1'b0);
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b0);
    line_bit(1'b1);
    rx_input = 1'b1;
    tick(3);
    check("abort_busy", {31'h0, rx_active}, 1);
    rx_enable = 1'b0;
    tick(1);
    check("abort_active", {31'h0, rx_active}, 0);
    tick(60);
    check("abort_done_cnt", done_cnt, 4);
    check("abort_word", {24'h0, received_word}, 32'h12);
    rx_enable = 1'b1;
    tick(5);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    tick(10);
    check("f81_word", {24'h0, received_word}, 32'h81);
    check("f81_done_cnt", done_cnt, 5);

    // Async reset mid-data, between edges.
    line_bit(1'b0);
    line_bit(1'b0);
    line_bit(1'b0);
    line_bit(1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_word", {24'h0, received_word}, 32'h00);
    check("arst_active", {31'h0, rx_active}, 0);
    check("arst_done", {31'h0, rx_done}, 0);
    rx_input = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(30);
    check("final_done_cnt", done_cnt, 5);
    check("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sn_uart_rx.md
Name: sn_uart_rx

Overview:
- UART serial receiver for the sn_ UART path. Oversamples an asynchronous serial line at P_CLKS_PER_BIT system clocks per bit.
- Frames are 1 start bit (0), data bits LSB-first, and 1 stop bit (1).
- Delivers the data byte on received_word with a one-cycle rx_done strobe, and flags frame-in-progress on rx_active.

Parameters:
- P_CLKS_PER_BIT, 10, system clocks per serial bit; must be ≥4.
- P_NUM_BITS_TO_RECEIVE, 10, total frame bits including start and stop; legal range 3..10.
  - Data bits D = P_NUM_BITS_TO_RECEIVE-2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rx_enable  input  1  receiver enable; 0 holds/aborts to IDLE.
- rx_input  input  1  serial line, idles high; asynchronous to clk.
- received_word  output  8  last correctly framed data word; bit0 = first data bit received.
- rx_done  output  1  one-cycle pulse when a valid frame completes.
- rx_active  output  1  high while a frame is being received.

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE; received_word=8'h00; rx_done=0; rx_active=0.
  - counters 0; synchronizer flops=1.
- Input synchronizer: rx_input passes through 2 flops; rx_s below is the synchronized value (2-cycle latency). rx_input is used nowhere else.
- Bit counter: 0..D-1. Clock counter: 0..P_CLKS_PER_BIT-1. H = P_CLKS_PER_BIT/2 (floor).
- IDLE:
  - rx_active=0.
  - If rx_enable=1 and rx_s=0, go to START, clear counters, rx_active=1 next cycle. Call this detection cycle S.
- START:
  - At S+H, sample rx_s. If 0, go to DATA and reset the clock counter. If 1 (glitch), return to IDLE, rx_active=0, no rx_done.
- DATA:
  - Data bit k (k=0..D-1) is sampled at S+H+(k+1)*P_CLKS_PER_BIT and stored into shift/word bit k.
  - After bit D-1, go to STOP.
- STOP:
  - Sample at S+H+(D+1)*P_CLKS_PER_BIT.
  - If rx_s=1: on the next cycle, received_word takes the assembled data (bits above D-1 forced 0), rx_done=1 for exactly one cycle, and the FSM returns to IDLE with rx_active=0.
  - If rx_s=0 (framing error): discard data, received_word unchanged, no rx_done. Go to IDLE, which must see rx_s=1 before re-arming (WAIT_HIGH sub-state).
- rx_active: 1 from the cycle after S through the rx_done cycle inclusive; 0 otherwise.
- received_word holds its value between frames; it changes only on the rx_done cycle.
- rx_enable=0 in any state: next cycle go to IDLE, rx_active=0, no rx_done, received_word unchanged, partial data discarded. rx_enable=1 with line low in IDLE starts a frame (no edge required).
- Back-to-back frames: a start bit immediately after the stop bit is detected normally once the FSM is in IDLE. Detection is from the cycle after rx_done.
- Async reset asserted mid-frame: immediate return to reset values; rx_done is not pulsed.

Test Plan:
- P=10, N=10. After reset release, set rx_enable=1 and drive line bits 0,1,0,0,1,1,0,0,1,1, each held 10 clocks. Required: received_word=8'h99, a single-cycle rx_done, and rx_active high for the frame duration. Then rx_enable=0 and idle 150 clocks: no further rx_done, word stays 8'h99.
- Frame data 0x3C (line 0,0,0,1,1,1,1,0,0,1) followed immediately by frame 0xA5. Required: two rx_done pulses, 100 clocks apart, with words 0x3C then 0xA5.
- Start glitch: line low for 3 clocks, then high. Required: return to IDLE, rx_active pulse ≤H+1 cycles, no rx_done, received_word unchanged.
- Framing error: valid start + 0x55, stop bit=0. Required: no rx_done, word unchanged. No new frame until the line returns high and falls again; the next valid 0x12 frame is received correctly.
- Abort: drop rx_enable at data bit 4. Required: rx_active=0 next cycle, no rx_done. A later full frame 0x81 is received.
- Async reset: assert rst=0 mid-data, between clock edges. Required: immediate received_word=0, rx_active=0, rx_done=0.
